// File: rtl/inst_fetch_axi_responder_if.sv
// AXI-Lite read-only (AR/R) channel bundle between the instruction-fetch responder and the interconnect.
interface inst_fetch_axi_responder_if;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_araddr, m_arprot, m_arvalid, m_rready,
        input  m_arready, m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_araddr, m_arprot, m_arvalid, m_rready,
        output m_arready, m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/inst_fetch_axi_responder.sv
// Instruction-fetch responder: 2-entry word buffer, misses filled over AXI-Lite AR/R.
// Optional next-word prefetch when IFETCH_PREFETCH_EN is defined.
module inst_fetch_axi_responder #(
    parameter logic [2:0]  ARPROT_VAL = 3'b100,
    parameter logic [31:0] ERR_DATA   = 32'h0000_0000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rom_ce_i,
    input  logic [31:0]                        rom_addr_i,
    output logic [31:0]                        rom_data_o,
    output logic                               stall_req_o,
    output logic                               fetch_err_o,
    inst_fetch_axi_responder_if.master         axi
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e      state_q;
    logic [1:0]  vld_q;
    logic [29:0] tag_q  [2];
    logic [31:0] data_q [2];
    logic        repl_q;
    logic        fill_idx_q;
    logic [29:0] target_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        err_q;

    logic [29:0] cur_tag_s;
    logic [29:0] next_tag_s;
    logic [1:0]  hit_vec_s;
    logic [1:0]  fill_vec_s;
    logic        hit_s;
    logic        hit_idx_s;
    logic        miss_s;
    logic        pf_req_s;
    logic        fill_idx_s;
    logic [31:0] fill_data_s;
    logic [1:0]  addr_lsb_unused_s;
`ifdef IFETCH_PREFETCH_EN
    logic [1:0]  next_vec_s;
`endif

    assign addr_lsb_unused_s = rom_addr_i[1:0];

    // Buffer lookup for the demand address, the in-flight fill target and the next sequential word
    always_comb begin
        hit_vec_s  = 2'b00;
        fill_vec_s = 2'b00;
        cur_tag_s  = rom_addr_i[31:2];
        next_tag_s = cur_tag_s + 30'd1;
`ifdef IFETCH_PREFETCH_EN
        next_vec_s = 2'b00;
`endif
        for (int i = 0; i < 2; i++) begin
            hit_vec_s[i]  = vld_q[i] && (tag_q[i] == cur_tag_s);
            fill_vec_s[i] = vld_q[i] && (tag_q[i] == target_q);
`ifdef IFETCH_PREFETCH_EN
            next_vec_s[i] = vld_q[i] && (tag_q[i] == next_tag_s);
`endif
        end
        hit_s     = rom_ce_i && (|hit_vec_s);
        hit_idx_s = hit_vec_s[1];
        miss_s    = rom_ce_i && !(|hit_vec_s);
        // A fill whose word is already buffered overwrites that entry so no duplicates appear
        if (|fill_vec_s) begin
            fill_idx_s = fill_vec_s[1];
        end else begin
            fill_idx_s = fill_idx_q;
        end
        if (axi.m_rresp == 2'b00) begin
            fill_data_s = axi.m_rdata;
        end else begin
            fill_data_s = ERR_DATA;
        end
`ifdef IFETCH_PREFETCH_EN
        pf_req_s = hit_s && !(|next_vec_s);
`else
        pf_req_s = 1'b0;
`endif
    end

    assign rom_data_o    = (hit_s && !rst) ? data_q[hit_idx_s] : 32'h0000_0000;
    assign stall_req_o   = miss_s && !rst;
    assign fetch_err_o   = err_q;
    assign axi.m_araddr  = {target_q, 2'b00};
    assign axi.m_arprot  = ARPROT_VAL;
    assign axi.m_arvalid = arvalid_q;
    assign axi.m_rready  = rready_q;

    // Fill FSM, buffer storage and replacement pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vld_q      <= 2'b00;
            repl_q     <= 1'b0;
            fill_idx_q <= 1'b0;
            target_q   <= 30'd0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                tag_q[i]  <= 30'd0;
                data_q[i] <= 32'h0000_0000;
            end
        end else begin
            err_q <= 1'b0;
            if (hit_s) begin
                repl_q <= ~hit_idx_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (miss_s) begin
                        target_q   <= cur_tag_s;
                        fill_idx_q <= repl_q;
                        arvalid_q  <= 1'b1;
                        state_q    <= ST_ADDR;
                    end else if (pf_req_s) begin
                        // Prefetch lands in the entry not being hit so the current word survives
                        target_q   <= next_tag_s;
                        fill_idx_q <= ~hit_idx_s;
                        arvalid_q  <= 1'b1;
                        state_q    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (axi.m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (axi.m_rvalid) begin
                        rready_q           <= 1'b0;
                        vld_q[fill_idx_s]  <= 1'b1;
                        tag_q[fill_idx_s]  <= target_q;
                        data_q[fill_idx_s] <= fill_data_s;
                        err_q              <= (axi.m_rresp != 2'b00);
                        state_q            <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi_responder.sv
// Directed bench for inst_fetch_axi_responder with a configurable AXI-Lite read slave model.
module tb_inst_fetch_axi_responder;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        ferr;

    int checks = 0;
    int errors = 0;

`ifdef IFETCH_PREFETCH_EN
    localparam int SEQ_STALLS = 2;
`else
    localparam int SEQ_STALLS = 3;
`endif

    inst_fetch_axi_responder_if bus ();

    inst_fetch_axi_responder dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (ce),
        .rom_addr_i  (addr),
        .rom_data_o  (rom_data),
        .stall_req_o (stall),
        .fetch_err_o (ferr),
        .axi         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave model
    int          ar_wait = 0;
    int          r_wait  = 0;
    logic [1:0]  rresp_cfg = 2'b00;
    int          ar_cnt;
    int          r_cnt;
    logic        r_pend;
    logic [31:0] r_addr;
    int          ar_total;
    logic [31:0] last_araddr;
    int          stab_viol;
    logic        prev_wait;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C01_1234;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus.m_arready = (ar_cnt >= ar_wait);
    assign bus.m_rvalid  = r_pend && (r_cnt >= r_wait);
    assign bus.m_rdata   = mem_word(r_addr);
    assign bus.m_rresp   = rresp_cfg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_cnt      <= 0;
            r_cnt       <= 0;
            r_pend      <= 1'b0;
            r_addr      <= 32'h0;
            ar_total    <= 0;
            last_araddr <= 32'hFFFF_FFFF;
            stab_viol   <= 0;
            prev_wait   <= 1'b0;
            prev_addr   <= 32'h0;
        end else begin
            if (bus.m_arvalid && bus.m_arready) begin
                ar_cnt      <= 0;
                r_pend      <= 1'b1;
                r_cnt       <= 0;
                r_addr      <= bus.m_araddr;
                ar_total    <= ar_total + 1;
                last_araddr <= bus.m_araddr;
            end else if (bus.m_arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (bus.m_rvalid && bus.m_rready) r_pend <= 1'b0;
            else if (r_pend) r_cnt <= r_cnt + 1;
            if (prev_wait && (!bus.m_arvalid || bus.m_araddr != prev_addr))
                stab_viol <= stab_viol + 1;
            prev_wait <= bus.m_arvalid && !bus.m_arready;
            prev_addr <= bus.m_araddr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a fetch at posedge+1 and count stall cycles until served
    task automatic fetch(input logic [31:0] a, output int stalls, output logic [31:0] d);
        ce = 1'b1;
        addr = a;
        stalls = 0;
        #1;
        while (stall === 1'b1 && stalls < 60) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        d = rom_data;
    endtask

    task automatic drain();
        ce = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (!bus.m_arvalid && !bus.m_rready) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] d;
        int          snap;

        rst  = 1'b1;
        ce   = 1'b1;
        addr = 32'h0000_0040;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",   {31'd0, stall}, 32'd0);
        chk("rst_data",    rom_data, 32'h0);
        chk("rst_arvalid", {31'd0, bus.m_arvalid}, 32'd0);
        chk("rst_rready",  {31'd0, bus.m_rready}, 32'd0);
        chk("rst_araddr",  bus.m_araddr, 32'h0);
        chk("rst_ferr",    {31'd0, ferr}, 32'd0);
        chk("arprot",      {29'd0, bus.m_arprot}, 32'd4);
        rst = 1'b0;
        #1;
        chk("post_rst_miss", {31'd0, stall}, 32'd1);
        ar_wait = 10;
        @(posedge clk); #1;
        chk("addr_arvalid", {31'd0, bus.m_arvalid}, 32'd1);
        chk("addr_araddr",  bus.m_araddr, 32'h0000_0040);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_arvalid", {31'd0, bus.m_arvalid}, 32'd0);
        chk("abort_rready",  {31'd0, bus.m_rready}, 32'd0);
        chk("abort_stall",   {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_buf_empty", {31'd0, stall}, 32'd1);
        ce = 1'b0;
        ar_wait = 0;
        @(posedge clk); #1;

        // miss then hit
        fetch(32'hBFC0_0000, st, d);
        chk("miss_stalls", st, 32'd3);
        chk("miss_data",   d, 32'h3C01_1234);
        chk("miss_araddr", last_araddr, 32'hBFC0_0000);
        @(posedge clk); #1;
        snap = ar_total;
        fetch(32'hBFC0_0000, st, d);
        chk("refetch_stalls", st, 32'd0);
        chk("refetch_data",   d, 32'h3C01_1234);
        chk("refetch_no_ar",  ar_total, snap);

        // backpressure
        drain();
        ar_wait = 4;
        r_wait  = 2;
        fetch(32'h0000_0200, st, d);
        chk("bp_stalls", st, 32'd9);
        chk("bp_data",   d, 32'h5A5A_0200);
        chk("bp_ar_stable", stab_viol, 32'd0);

        // error response
        drain();
        ar_wait   = 0;
        r_wait    = 0;
        rresp_cfg = 2'b10;
        fetch(32'h0000_0100, st, d);
        chk("err_stalls", st, 32'd3);
        chk("err_data",   d, 32'h0);
        chk("err_pulse",  {31'd0, ferr}, 32'd1);
        rresp_cfg = 2'b00;
        @(posedge clk); #1;
        chk("err_pulse_end", {31'd0, ferr}, 32'd0);
        snap = ar_total;
        fetch(32'h0000_0103, st, d);
        chk("lsb_hit_stalls", st, 32'd0);
        chk("lsb_hit_data",   d, 32'h0);
        chk("lsb_hit_no_ar",  ar_total, snap);

        // abandon during DATA
        drain();
        r_wait = 3;
        ce   = 1'b1;
        addr = 32'h0000_0500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abandon_in_data", {31'd0, bus.m_rready}, 32'd1);
        ce = 1'b0;
        #1;
        chk("abandon_stall", {31'd0, stall}, 32'd0);
        snap = ar_total;
        drain();
        chk("abandon_rready_done", {31'd0, bus.m_rready}, 32'd0);
        chk("abandon_no_ar", ar_total, snap);
        r_wait = 0;
        fetch(32'h0000_0503, st, d);
        chk("abandon_fill_stalls", st, 32'd0);
        chk("abandon_fill_data",   d, 32'h5A5A_0500);

        // sequential stream across the wrap
        drain();
        fetch(32'hFFFF_FFF8, st, d);
        chk("seq0_stalls", st, 32'd3);
        chk("seq0_data",   d, 32'hA5A5_FFF8);
        @(posedge clk); #1;
        fetch(32'hFFFF_FFFC, st, d);
        chk("seq1_stalls", st, SEQ_STALLS);
        chk("seq1_data",   d, 32'hA5A5_FFFC);
        @(posedge clk); #1;
        fetch(32'h0000_0000, st, d);
        chk("seq2_stalls", st, SEQ_STALLS);
        chk("seq2_data",   d, 32'h5A5A_0000);
        chk("seq_wrap_araddr", last_araddr, 32'h0000_0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
